debug_tasks: RTL and testbench
==============================

DEBUG_TASKS -- requirements
Module: debug_tasks

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NAME_BYTES, 16, width in bytes of the name input.
- ID_W, 8, width of the id input (at most 3 decimal digits at default).
- TS_W, 16, timestamp counter width (at most 5 decimal digits at default).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, request to emit one prefix.
- name, in, 8*NAME_BYTES, packed ASCII label, right-justified, zero-padded.
- id, in, ID_W, unsigned instance number.
- char_out, out, 8, ASCII character.
- char_valid, out, 1, char_out holds a valid character.
- char_ready, in, 1, consumer accepts char_out.
- busy, out, 1, a prefix is being generated or emitted.
- done, out, 1, one-cycle pulse when the prefix is complete.

Function
REQ-003 Free-running timestamp counter.
- Increments by 1 on every rising clk edge while reset is high.
- Wraps from 2^TS_W-1 to 0.
- Not visible as a port.
REQ-004 Start acceptance.
- start is accepted on an edge where start=1 and busy=0.
- On acceptance, the block captures name, id and the pre-increment timestamp T, and busy goes high.
- start while busy=1 is ignored.
REQ-005 Emitted string, exactly: "[" T "] " NAME " " ID ": ".
- T and ID are unsigned decimal, no leading zeros; the value 0 is emitted as "0".
REQ-006 NAME consists of the non-zero bytes of name, most significant byte first; zero bytes are skipped.
- If all name bytes are zero, NAME and its following space are omitted, giving "[T] ID: ".
REQ-007 Character handshake.
- A character transfers on an edge where char_valid=1 and char_ready=1.
- char_out and char_valid are held stable while char_valid=1 and char_ready=0.
REQ-008 Latency.
- The first character becomes valid at most 24 cycles after start acceptance.
- With char_ready held at 1, no more than 8 idle cycles occur between consecutive characters.
REQ-009 Decimal conversion is sequential (iterative subtraction or shift-add-3); no combinational divider.
REQ-010 Completion.
- After the final space transfers, char_valid drops to 0 on that edge.
- done=1 for exactly the next cycle, and busy=0 in that same cycle.
- A new start is accepted in the done cycle.
REQ-011 Internal states: IDLE, CONV (binary-to-decimal), EMIT, DONE.
- IDLE->CONV on start acceptance.
- CONV->EMIT when both decimal conversions are complete.
- EMIT->DONE when the last character transfers.
- DONE->IDLE unconditionally, or DONE->CONV if start=1.
REQ-012 Captured name/id/T are unaffected by input changes after acceptance.

Reset
REQ-013 While reset=0, asynchronously:
- char_valid=0, char_out=8'h00, busy=0, done=0.
- Timestamp = 0, state = IDLE.
REQ-014 Reset asserted mid-stream abandons the string; no done pulse is produced.
- After release, the block accepts start normally.
REQ-015 The first rising edge after reset release sees timestamp 0.

Verification
REQ-016 Release reset, start at the edge where the timestamp is 42, name="Packet Source", id=3, char_ready=1 -> stream "[42] Packet Source 3: ", then one done pulse.
REQ-017 Same request with char_ready toggling 1/0 every cycle -> identical stream; no character dropped or duplicated; char_out stable while stalled.
REQ-018 name=0, id=0, T=0 -> stream "[0] 0: ".
REQ-019 id=255, T=65535 with TS_W=16 -> "[65535] <name> 255: "; the next request one cycle later shows the wrapped timestamp.
REQ-020 Second start pulsed while busy -> ignored; exactly one string and one done.
REQ-021 Reset asserted after 5 characters -> outputs 0 immediately, no done; a new start after release produces a complete, correct string.

Source files
------------

// File: rtl/debug_tasks.sv
// Debug-print prefix generator: on start, snapshots a free-running timestamp, a
// name and an id, and streams "[T] NAME ID: " one ASCII character per handshake.
module debug_tasks #(
  parameter int NAME_BYTES = 16,
  parameter int ID_W       = 8,
  parameter int TS_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*NAME_BYTES-1:0] name,
  input  logic [ID_W-1:0]         id,
  output logic [7:0]              char_out,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    busy,
  output logic                    done
);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  localparam int T_DIG = dec_digits(TS_W);
  localparam int I_DIG = dec_digits(ID_W);
  localparam int DIG   = (T_DIG > I_DIG) ? T_DIG : I_DIG;
  localparam int BCD_W = 4 * DIG;
  localparam int BIN_W = (TS_W > ID_W) ? TS_W : ID_W;
  localparam int STEPS = (BIN_W > NAME_BYTES) ? BIN_W : NAME_BYTES;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int NB_W  = $clog2(NAME_BYTES + 1);
  localparam int IDX_W = $clog2(((NAME_BYTES > DIG) ? NAME_BYTES : DIG) + 1);
  localparam int NW    = 8 * NAME_BYTES;

  typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} state_t;
  typedef enum logic [3:0] {S_LB, S_TD, S_RB, S_SP1, S_NM, S_SP2, S_ID, S_COL, S_SP3, S_END} seg_t;

  // One shift-add-3 iteration: correct digits >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic in_bit);
    logic [BCD_W-1:0] a;
    a = b;
    for (int k = 0; k < DIG; k++)
      if (b[4*k +: 4] >= 4'd5) a[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return {a[BCD_W-2:0], in_bit};
  endfunction

  function automatic logic [IDX_W-1:0] msd(input logic [BCD_W-1:0] b);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < DIG; k++)
      if (b[4*k +: 4] != 4'd0) r = IDX_W'(k);
    return r;
  endfunction

  state_t           state_q;
  seg_t             seg_q, seg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       char_q;
  logic             vld_q, busy_q, done_q;
  logic [NW-1:0]    nsr_q, nbuf_q;
  logic [NB_W-1:0]  ncnt_q;
  logic [BIN_W-1:0] tbin_q, ibin_q;
  logic [BCD_W-1:0] tbcd_q, ibcd_q;
  logic             accept;
  logic [7:0]       cur_char, nsr_top;
  logic [IDX_W-1:0] t_msd, i_msd;

  assign accept  = start && (state_q == IDLE || state_q == DONE);
  assign nsr_top = nsr_q[NW-1 -: 8];
  assign t_msd   = msd(tbcd_q);
  assign i_msd   = msd(ibcd_q);

  // Snapshot + conversion datapath; name bytes are compacted (zeros dropped) in parallel.
  always_ff @(posedge clk) begin
    if (accept) begin
      nsr_q  <= name;
      nbuf_q <= '0;
      ncnt_q <= '0;
      tbin_q <= BIN_W'(ts_q);
      ibin_q <= BIN_W'(id);
      tbcd_q <= '0;
      ibcd_q <= '0;
    end else if (state_q == CONV) begin
      if (cnt_q < CNT_W'(BIN_W)) begin
        tbcd_q <= dd_step(tbcd_q, tbin_q[BIN_W-1]);
        ibcd_q <= dd_step(ibcd_q, ibin_q[BIN_W-1]);
        tbin_q <= tbin_q << 1;
        ibin_q <= ibin_q << 1;
      end
      if (cnt_q < CNT_W'(NAME_BYTES)) begin
        nsr_q <= nsr_q << 8;
        if (nsr_top != 8'h00) begin
          nbuf_q <= (nbuf_q << 8) | NW'(nsr_top);
          ncnt_q <= ncnt_q + 1'b1;
        end
      end
    end
  end

  // Character sequencer: seg_q/idx_q point at the next character to present.
  always_comb begin
    cur_char = 8'h00;
    seg_d    = seg_q;
    idx_d    = idx_q;
    case (seg_q)
      S_LB:  begin cur_char = 8'h5B; seg_d = S_TD; idx_d = t_msd; end
      S_TD:  begin
        cur_char = {4'h3, tbcd_q[4*idx_q +: 4]};
        if (idx_q == '0) seg_d = S_RB;
        else idx_d = idx_q - 1'b1;
      end
      S_RB:  begin cur_char = 8'h5D; seg_d = S_SP1; end
      S_SP1: begin
        cur_char = 8'h20;
        if (ncnt_q == '0) begin seg_d = S_ID; idx_d = i_msd; end
        else begin seg_d = S_NM; idx_d = IDX_W'(ncnt_q) - 1'b1; end
      end
      S_NM:  begin
        cur_char = nbuf_q[8*idx_q +: 8];
        if (idx_q == '0) seg_d = S_SP2;
        else idx_d = idx_q - 1'b1;
      end
      S_SP2: begin cur_char = 8'h20; seg_d = S_ID; idx_d = i_msd; end
      S_ID:  begin
        cur_char = {4'h3, ibcd_q[4*idx_q +: 4]};
        if (idx_q == '0) seg_d = S_COL;
        else idx_d = idx_q - 1'b1;
      end
      S_COL: begin cur_char = 8'h3A; seg_d = S_SP3; end
      S_SP3: begin cur_char = 8'h20; seg_d = S_END; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ts_q    <= '0;
      cnt_q   <= '0;
      seg_q   <= S_LB;
      idx_q   <= '0;
      char_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ts_q   <= ts_q + 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CONV;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        CONV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_q <= EMIT;
            seg_q   <= S_LB;
            idx_q   <= '0;
          end
        end
        EMIT: begin
          if (!vld_q || char_ready) begin
            if (seg_q == S_END) begin
              vld_q   <= 1'b0;
              char_q  <= 8'h00;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              char_q <= cur_char;
              vld_q  <= 1'b1;
              seg_q  <= seg_d;
              idx_q  <= idx_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_out   = char_q;
  assign char_valid = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_debug_tasks.sv
// Directed bench for debug_tasks: table of prefix requests with hand-written expected
// strings, plus sequences for busy-start, mid-stream reset and timestamp wrap.
module tb_debug_tasks;
  localparam int NB = 16;
  localparam int IW = 8;
  localparam int TW = 16;
  localparam int SW = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic char_ready = 1'b0;
  logic [8*NB-1:0] name = '0;
  logic [IW-1:0] id = '0;
  logic [7:0] char_out;
  logic char_valid, busy, done;
  logic [TW-1:0] tb_ts;
  int total = 0;
  int bad = 0;

  debug_tasks #(.NAME_BYTES(NB), .ID_W(IW), .TS_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .name(name), .id(id),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value seen by the next rising edge.
  always @(posedge clk or negedge reset)
    if (!reset) tb_ts <= '0;
    else tb_ts <= tb_ts + 1'b1;

  typedef struct {
    int              n;
    logic [127:0]    nm;
    logic [7:0]      idv;
    bit              tog;
    logic [SW-1:0]   exp;
  } vec_t;

  task automatic chk(input string what, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  task automatic chk_s(input string what, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", what, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] app(input logic [SW-1:0] r, input logic [7:0] c);
    return {r[SW-9:0], c};
  endfunction

  function automatic logic [SW-1:0] app_dec(input logic [SW-1:0] r, input int v);
    int d[12];
    int n;
    logic [SW-1:0] x;
    n = 0;
    x = r;
    do begin
      d[n] = v % 10;
      v = v / 10;
      n++;
    end while (v > 0);
    for (int i = n - 1; i >= 0; i--) x = app(x, 8'(8'h30 + d[i]));
    return x;
  endfunction

  function automatic logic [SW-1:0] fmt(input int t, input logic [127:0] nm, input int idv);
    logic [SW-1:0] r;
    bit any;
    r = '0;
    any = 0;
    r = app(r, 8'h5B);
    r = app_dec(r, t);
    r = app(r, 8'h5D);
    r = app(r, 8'h20);
    for (int b = NB - 1; b >= 0; b--)
      if (nm[8*b +: 8] != 8'h00) begin
        r = app(r, nm[8*b +: 8]);
        any = 1;
      end
    if (any) r = app(r, 8'h20);
    r = app_dec(r, idv);
    r = app(r, 8'h3A);
    r = app(r, 8'h20);
    return r;
  endfunction

  // Reset, release on a falling edge, and pulse start so the edge seeing timestamp n accepts it.
  task automatic go(input int n, input logic [127:0] nm, input logic [7:0] idv);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    char_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    name = nm;
    id = idv;
    if (n == 0) start = 1'b1;
    else begin
      repeat (n) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input bit tog, input int stop_n, output logic [SW-1:0] cap,
                            output int nch, output bit got_done);
    bit pv, pr;
    logic [7:0] pc;
    int first, last, maxgap;
    pv = 0; pr = 0; pc = 8'h00;
    first = -1; last = -1; maxgap = 0;
    cap = '0; nch = 0; got_done = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      char_ready = tog ? k[0] : 1'b1;
      #1;
      if (pv && !pr) begin
        total++;
        if (!char_valid || char_out !== pc) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b char=%02h expected valid=1 char=%02h", char_valid, char_out, pc);
        end
      end
      if (char_valid && first < 0) first = k;
      if (done) begin
        got_done = 1;
        chk("done_busy", int'(busy), 0);
        chk("done_valid", int'(char_valid), 0);
        break;
      end
      if (char_valid && char_ready) begin
        cap = app(cap, char_out);
        nch++;
        if (last > 0 && k - last - 1 > maxgap) maxgap = k - last - 1;
        last = k;
        if (stop_n > 0 && nch == stop_n) break;
      end
      pv = char_valid; pr = char_ready; pc = char_out;
    end
    total++;
    if (first < 1 || first > 24) begin
      bad++;
      $display("FAIL first_latency: got %0d cycles expected 1..24", first);
    end
    if (!tog) chk("max_gap_le8", int'(maxgap <= 8), 1);
  endtask

  task automatic quiet(input int n, output int nd, output int nv);
    nd = 0; nv = 0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (done) nd++;
      if (char_valid) nv++;
    end
  endtask

  initial begin
    vec_t vt[6];
    logic [SW-1:0] cap;
    int nch, nd, nv, t_exp;
    bit gd;

    vt[0] = '{n: 42, nm: 128'("Packet Source"), idv: 8'd3, tog: 1'b0, exp: SW'("[42] Packet Source 3: ")};
    vt[1] = '{n: 42, nm: 128'("Packet Source"), idv: 8'd3, tog: 1'b1, exp: SW'("[42] Packet Source 3: ")};
    vt[2] = '{n: 0, nm: 128'(0), idv: 8'd0, tog: 1'b0, exp: SW'("[0] 0: ")};
    vt[3] = '{n: 7, nm: 128'({8'h61, 8'h00, 8'h62}), idv: 8'd100, tog: 1'b1, exp: SW'("[7] ab 100: ")};
    vt[4] = '{n: 1000, nm: 128'("X"), idv: 8'd10, tog: 1'b0, exp: SW'("[1000] X 10: ")};
    vt[5] = '{n: 9, nm: 128'({8'h48, 8'h00, 8'h00, 8'h69, 8'h00}), idv: 8'd0, tog: 1'b0, exp: SW'("[9] Hi 0: ")};

    #12;
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_char", int'(char_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    for (int i = 0; i < 6; i++) begin
      go(vt[i].n, vt[i].nm, vt[i].idv);
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      run_stream(vt[i].tog, 0, cap, nch, gd);
      chk_s($sformatf("v%0d_stream", i), cap, vt[i].exp);
      chk($sformatf("v%0d_done", i), int'(gd), 1);
      quiet(3, nd, nv);
      chk($sformatf("v%0d_no_extra_done", i), nd, 0);
    end

    // Start pulsed while busy is ignored; input changes after acceptance do not leak in.
    go(10, 128'("Dbg"), 8'd3);
    repeat (3) @(negedge clk);
    start = 1'b1;
    id = 8'd99;
    name = 128'("Other");
    @(negedge clk);
    start = 1'b0;
    run_stream(1'b0, 0, cap, nch, gd);
    chk_s("busy_start_stream", cap, SW'("[10] Dbg 3: "));
    chk("busy_start_done", int'(gd), 1);
    quiet(30, nd, nv);
    chk("busy_start_one_done", nd, 0);
    chk("busy_start_no_second", nv, 0);

    // Reset after five characters abandons the string without a done pulse.
    go(5, 128'("Packet Source"), 8'd3);
    run_stream(1'b0, 5, cap, nch, gd);
    chk_s("rst_mid_partial", cap, SW'("[5] P"));
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", int'(char_valid), 0);
    chk("rst_mid_char", int'(char_out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    quiet(4, nd, nv);
    chk("rst_mid_no_done", nd + nv, 0);
    go(20, 128'("Node"), 8'd7);
    run_stream(1'b0, 0, cap, nch, gd);
    chk_s("rst_after_stream", cap, SW'("[20] Node 7: "));
    chk("rst_after_done", int'(gd), 1);

    // Largest timestamp and id, then a request accepted in the done cycle sees the wrapped count.
    go(65535, 128'("Packet Source"), 8'd255);
    run_stream(1'b0, 0, cap, nch, gd);
    chk_s("wrap_max_stream", cap, SW'("[65535] Packet Source 255: "));
    chk("wrap_max_done", int'(gd), 1);
    start = 1'b1;
    name = 128'("Wrap");
    id = 8'd1;
    t_exp = int'(tb_ts);
    @(negedge clk);
    start = 1'b0;
    run_stream(1'b0, 0, cap, nch, gd);
    chk_s("wrap_next_stream", cap, fmt(t_exp, 128'("Wrap"), 1));
    chk("wrap_next_done", int'(gd), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
